sort_nb: RTL
============

SORT_NB -- requirements
Module: sort_nb

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each data word.
REQ-002 Parameter DEPTH, default 8, words per sort batch; legal range 2..64.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_data  input  WIDTH  unsigned word to load.
REQ-006 Port in_valid  input  1  in_data valid this cycle.
REQ-007 Port in_ready  output  1  block accepts a word this cycle.
REQ-008 Port desc  input  1  sort order: 0 ascending, 1 descending; sampled with the first word of a batch.
REQ-009 Port out_data  output  WIDTH  current sorted word.
REQ-010 Port out_valid  output  1  out_data valid.
REQ-011 Port out_ready  input  1  consumer takes out_data this cycle.
REQ-012 Port out_last  output  1  out_data is the final word of the batch.
REQ-013 Port busy  output  1  block is in the SORT state.

Function
REQ-014 The block SHALL implement three states: LOAD, SORT and OUT; the reset state is LOAD.
REQ-015 In LOAD, in_ready SHALL be 1; a word is accepted when in_valid and in_ready are both 1, and is written to element[wr_idx], after which wr_idx increments.
REQ-016 On acceptance of word 0, desc SHALL be latched into an order register; desc is ignored at all other times.
REQ-017 On acceptance of word DEPTH-1, the block SHALL move to SORT on the next edge, with wr_idx cleared and phase counter cleared.
REQ-018 In SORT, in_ready SHALL be 0 and busy 1; each cycle performs one odd-even transposition phase p = 0..DEPTH-1.
REQ-019 Even phases SHALL compare pairs (0,1),(2,3),...; odd phases SHALL compare pairs (1,2),(3,4),...; an unpaired end element is left unchanged.
REQ-020 A pair (i,i+1) SHALL swap only when element[i] > element[i+1] (ascending) or element[i] < element[i+1] (descending), unsigned; equal values never swap.
REQ-021 After exactly DEPTH SORT cycles, the block SHALL move to OUT with rd_idx = 0.
REQ-022 In OUT, out_valid SHALL be 1, out_data = element[rd_idx], and out_last = 1 iff rd_idx = DEPTH-1; in_ready SHALL be 0.
REQ-023 When out_valid and out_ready are both 1, rd_idx SHALL increment; out_data and out_last SHALL hold stable while out_ready is 0.
REQ-024 A transfer with out_last = 1 SHALL return the block to LOAD on the next edge, with out_valid 0 and in_ready 1 in that cycle.
REQ-025 Latency: when the last input is accepted at edge t, out_valid SHALL first be 1 in the cycle after edge t+DEPTH+1.
REQ-026 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside OUT.
REQ-027 Index and phase counters SHALL be sized to represent 0..DEPTH-1 and SHALL never wrap past DEPTH-1.

Reset
REQ-028 While rst is 1, the state SHALL be LOAD, all element registers, wr_idx, rd_idx, phase and the order register SHALL be 0, and the outputs SHALL be out_valid 0, out_data 0, out_last 0, busy 0, in_ready 1.
REQ-029 Reset asserted in any state, including mid-SORT or mid-OUT, SHALL discard the batch; the first word accepted after reset release is word 0 of a new batch.

Verification (WIDTH=8, DEPTH=8)
REQ-030 Ascending: load 5,3,8,1,9,2,7,4 with desc=0 -> out 1,2,3,4,5,7,8,9; out_last only on 9; out_valid rises 9 cycles after the last accept.
REQ-031 Descending with duplicates: load 3,3,0,255,128,3,0,7 with desc=1 -> out 255,128,7,3,3,3,0,0.
REQ-032 Worst case: load 8..1 ascending and 1..8 descending -> fully reversed within exactly 8 SORT cycles; busy high for exactly 8 cycles.
REQ-033 Backpressure: drive out_ready 1,0,0,1 repeating -> no word dropped or duplicated; out_data stable on every out_ready=0 cycle.
REQ-034 Reset mid-SORT at phase 3 -> all outputs at reset values next cycle; a subsequent batch 7,6,5,4,3,2,1,0 sorts to 0..7.
REQ-035 in_valid held 1 during SORT and OUT with value 0xAA -> no element changes; the sorted batch is unaffected.

Source files
------------

// File: rtl/sort_nb.sv
// Batch sorter: loads DEPTH words, sorts them with DEPTH odd-even transposition
// phases (one per cycle), then streams them out with a valid/ready handshake.
module sort_nb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             desc,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_elem     [DEPTH];
  logic [WIDTH-1:0] w_elem_nxt [DEPTH];
  logic [IW-1:0]    r_wr_idx;
  logic [IW-1:0]    r_rd_idx;
  logic [IW-1:0]    r_phase;
  logic             r_desc;
  logic             r_full;
  logic             w_accept;
  logic             w_xfer;

  assign w_accept = in_valid && in_ready;
  assign w_xfer   = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_full marks the one settling cycle between the final accept and SORT;
  // input is closed during it so no word is taken that cannot be stored.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = !r_full;
        if (r_full) begin
          w_state_nxt = S_SORT;
        end
      end
      S_SORT: begin
        busy = 1'b1;
        if (r_phase == LAST) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = r_elem[r_rd_idx];
        out_last  = (r_rd_idx == LAST);
        if (out_ready && (r_rd_idx == LAST)) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Pairs of one parity are disjoint, so all compare-exchanges run in parallel.
  always_comb begin
    w_elem_nxt = r_elem;
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (i[0] == r_phase[0]) begin
        if (r_desc ? (r_elem[i] < r_elem[i+1]) : (r_elem[i] > r_elem[i+1])) begin
          w_elem_nxt[i]   = r_elem[i+1];
          w_elem_nxt[i+1] = r_elem[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_elem[i] <= '0;
      end
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_phase  <= '0;
      r_desc   <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (r_full) begin
            r_full <= 1'b0;
          end else if (w_accept) begin
            r_elem[r_wr_idx] <= in_data;
            if (r_wr_idx == '0) begin
              r_desc <= desc;
            end
            if (r_wr_idx == LAST) begin
              r_wr_idx <= '0;
              r_phase  <= '0;
              r_full   <= 1'b1;
            end else begin
              r_wr_idx <= r_wr_idx + IW'(1);
            end
          end
        end
        S_SORT: begin
          r_elem <= w_elem_nxt;
          if (r_phase == LAST) begin
            r_phase  <= '0;
            r_rd_idx <= '0;
          end else begin
            r_phase <= r_phase + IW'(1);
          end
        end
        S_OUT: begin
          if (w_xfer) begin
            r_rd_idx <= (r_rd_idx == LAST) ? '0 : r_rd_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
